// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multi-cycle main control FSM: state codes and
// opcode / op_fun values seen by the ALU control.
package main_control_fsm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IF   = 3'd0;
    localparam state_t S_ID   = 3'd1;
    localparam state_t S_EX   = 3'd2;
    localparam state_t S_MEM  = 3'd3;
    localparam state_t S_WB   = 3'd4;
    localparam state_t S_HALT = 3'd5;

    // OP_R is the opcode value; in EX/MEM/WB the op_fun becomes {1, funct}.
    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_ADDI = 4'b0001;
    localparam logic [3:0] OP_SUBI = 4'b0010;
    localparam logic [3:0] OP_LW   = 4'b0011;
    localparam logic [3:0] OP_SW   = 4'b0100;
    localparam logic [3:0] OP_BEQ  = 4'b0110;
    localparam logic [3:0] OP_HALT = 4'b1111;
    localparam logic [3:0] OP_IDLE = 4'b0000;

endpackage

// File: rtl/main_control_fsm_timer.sv
// Saturating wait counter for the memory handshake; expired_o is high once
// MEM_TIMEOUT low-ready cycles have been counted since the last clear.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired_o = (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM (IF/ID/EX/MEM/WB/HALT) with a bounded memory
// handshake that aborts back to IF when mem_ready never arrives.
module main_control_fsm
    import main_control_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       mem_ready,
    input  logic       zero,
    output logic [3:0] op_fun,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch_taken,
    output logic       reg_write,
    output logic       illegal,
    output logic       mem_err,
    output logic       halted
);

    state_t     state_q, state_d;
    logic [3:0] opcode_q;
    logic [2:0] funct_q;
    logic       waiting;
    logic       expired;
    logic       timeout;
    logic [3:0] exec_op;

    assign waiting = (state_q == S_IF) || (state_q == S_MEM);
    assign timeout = waiting && expired && !mem_ready;
    assign exec_op = (opcode_q == OP_R) ? {1'b1, funct_q} : opcode_q;

    // Counter restarts whenever a fresh IF/MEM wait begins, including a re-fetch after abort.
    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (!waiting || (state_d != state_q) || timeout),
        .enable_i (waiting && !mem_ready),
        .expired_o(expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF: begin
                if (mem_ready) state_d = S_ID;
                else if (timeout) state_d = S_IF;
            end
            S_ID: begin
                case (opcode)
                    OP_R, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ: state_d = S_EX;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_IF;
                endcase
            end
            S_EX: begin
                case (opcode_q)
                    OP_LW, OP_SW: state_d = S_MEM;
                    OP_BEQ:       state_d = S_IF;
                    default:      state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (mem_ready) state_d = (opcode_q == OP_LW) ? S_WB : S_IF;
                else if (timeout) state_d = S_IF;
            end
            S_WB:    state_d = S_IF;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IF;
            opcode_q <= OP_IDLE;
            funct_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                opcode_q <= opcode;
                funct_q  <= funct;
            end
        end
    end

    // Outputs are forced low for as long as reset is held, even though the state already reads IF.
    always_comb begin
        op_fun       = OP_IDLE;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        branch_taken = 1'b0;
        reg_write    = 1'b0;
        illegal      = 1'b0;
        mem_err      = 1'b0;
        halted       = 1'b0;
        if (!reset) begin
            mem_err = timeout;
            case (state_q)
                S_IF: begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
                S_ID: begin
                    case (opcode)
                        OP_R, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_HALT: illegal = 1'b0;
                        default: illegal = 1'b1;
                    endcase
                end
                S_EX: begin
                    op_fun       = exec_op;
                    branch_taken = (opcode_q == OP_BEQ) && zero;
                end
                S_MEM: begin
                    op_fun    = exec_op;
                    mem_read  = (opcode_q == OP_LW);
                    mem_write = (opcode_q == OP_SW);
                end
                S_WB: begin
                    op_fun    = exec_op;
                    reg_write = 1'b1;
                end
                S_HALT:  halted = 1'b1;
                default: op_fun = OP_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// Scenario bench for main_control_fsm: per-cycle expected outputs are queued
// as stimulus is applied and popped/compared at the following falling edge.
module tb_main_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] opcode = 4'b0000;
    logic [2:0] funct = 3'b000;
    logic       mem_ready = 1'b0;
    logic       zero = 1'b0;
    logic [3:0] op_fun;
    logic       mem_read, mem_write, ir_write, pc_write;
    logic       branch_taken, reg_write, illegal, mem_err, halted;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic        rst;
        logic [3:0]  opc;
        logic [2:0]  fn;
        logic        rdy;
        logic        z;
        logic [12:0] exp;
    } step_t;

    logic [12:0] sb[$];
    logic [12:0] expv;
    logic [12:0] obs;

    localparam logic [8:0] F_NONE = 9'b0_0000_0000;
    localparam logic [8:0] F_RD   = 9'b1_0000_0000;
    localparam logic [8:0] F_WR   = 9'b0_1000_0000;
    localparam logic [8:0] F_IR   = 9'b0_0100_0000;
    localparam logic [8:0] F_PC   = 9'b0_0010_0000;
    localparam logic [8:0] F_BR   = 9'b0_0001_0000;
    localparam logic [8:0] F_RW   = 9'b0_0000_1000;
    localparam logic [8:0] F_IL   = 9'b0_0000_0100;
    localparam logic [8:0] F_ME   = 9'b0_0000_0010;
    localparam logic [8:0] F_HT   = 9'b0_0000_0001;
    localparam logic [8:0] F_FETCH = F_RD | F_IR | F_PC;

    main_control_fsm #(.MEM_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .zero(zero), .op_fun(op_fun),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .pc_write(pc_write), .branch_taken(branch_taken), .reg_write(reg_write),
        .illegal(illegal), .mem_err(mem_err), .halted(halted)
    );

    assign obs = {op_fun, mem_read, mem_write, ir_write, pc_write,
                  branch_taken, reg_write, illegal, mem_err, halted};

    always #5 clk = ~clk;

    function automatic step_t mk(input logic rst, input logic [3:0] opc, input logic [2:0] fn,
                                 input logic rdy, input logic z,
                                 input logic [3:0] opf, input logic [8:0] flags);
        step_t s;
        s.rst = rst; s.opc = opc; s.fn = fn; s.rdy = rdy; s.z = z;
        s.exp = {opf, flags};
        return s;
    endfunction

    task automatic applyStimulus(input step_t s);
        @(posedge clk);
        #1;
        reset     = s.rst;
        opcode    = s.opc;
        funct     = s.fn;
        mem_ready = s.rdy;
        zero      = s.z;
        sb.push_back(s.exp);
    endtask

    task automatic test_reset();
        step_t st[$];
        st.push_back(mk(1, 4'b0000, 3'b000, 1, 1, 4'b0000, F_NONE));
        st.push_back(mk(1, 4'b0011, 3'b111, 0, 1, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0000, F_RD));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL reset cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_rtype_back_to_back();
        step_t st[$];
        st.push_back(mk(1, 4'b0000, 3'b010, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0000, 3'b010, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0000, 3'b010, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0000, 3'b010, 1, 0, 4'b1010, F_NONE));
        st.push_back(mk(0, 4'b0000, 3'b010, 1, 0, 4'b1010, F_RW));
        st.push_back(mk(0, 4'b0001, 3'b101, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0001, 3'b101, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0001, 3'b101, 1, 0, 4'b0001, F_NONE));
        st.push_back(mk(0, 4'b0001, 3'b101, 1, 0, 4'b0001, F_RW));
        st.push_back(mk(0, 4'b0010, 3'b000, 0, 0, 4'b0000, F_RD));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL rtype cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_lw_delayed();
        step_t st[$];
        st.push_back(mk(1, 4'b0011, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0011, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0011, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0011, 3'b000, 1, 0, 4'b0011, F_NONE));
        for (int k = 0; k < 3; k++)
            st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0011, F_RD));
        st.push_back(mk(0, 4'b0011, 3'b000, 1, 0, 4'b0011, F_RD));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0011, F_RW));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0000, F_RD));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL lw cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_sw();
        step_t st[$];
        st.push_back(mk(1, 4'b0100, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0100, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0100, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0100, 3'b000, 1, 0, 4'b0100, F_NONE));
        st.push_back(mk(0, 4'b0100, 3'b000, 1, 0, 4'b0100, F_WR));
        st.push_back(mk(0, 4'b0100, 3'b000, 0, 0, 4'b0000, F_RD));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL sw cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_beq();
        step_t st[$];
        st.push_back(mk(1, 4'b0110, 3'b000, 1, 1, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0110, 3'b000, 1, 1, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0110, 3'b000, 1, 1, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0110, 3'b000, 1, 1, 4'b0110, F_BR));
        st.push_back(mk(0, 4'b0110, 3'b000, 1, 1, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0110, 3'b000, 1, 1, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0110, 3'b000, 1, 0, 4'b0110, F_NONE));
        st.push_back(mk(0, 4'b0110, 3'b000, 0, 1, 4'b0000, F_RD));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL beq cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_fetch_timeout();
        step_t st[$];
        st.push_back(mk(1, 4'b0000, 3'b000, 0, 0, 4'b0000, F_NONE));
        for (int k = 0; k < 15; k++)
            st.push_back(mk(0, 4'b0000, 3'b000, 0, 0, 4'b0000, F_RD));
        st.push_back(mk(0, 4'b0000, 3'b000, 0, 0, 4'b0000, F_RD | F_ME));
        for (int k = 0; k < 15; k++)
            st.push_back(mk(0, 4'b0000, 3'b000, 0, 0, 4'b0000, F_RD));
        st.push_back(mk(0, 4'b0000, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0000, 3'b000, 1, 0, 4'b0000, F_NONE));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL fetch_timeout cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_mem_timeout();
        step_t st[$];
        st.push_back(mk(1, 4'b0011, 3'b000, 0, 0, 4'b0000, F_NONE));
        for (int k = 0; k < 3; k++)
            st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0000, F_RD));
        st.push_back(mk(0, 4'b0011, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0011, F_NONE));
        for (int k = 0; k < 15; k++)
            st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0011, F_RD));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0011, F_RD | F_ME));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0000, F_RD));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL mem_timeout cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_ready_at_limit();
        step_t st[$];
        st.push_back(mk(1, 4'b0001, 3'b000, 0, 0, 4'b0000, F_NONE));
        for (int k = 0; k < 15; k++)
            st.push_back(mk(0, 4'b0001, 3'b000, 0, 0, 4'b0000, F_RD));
        st.push_back(mk(0, 4'b0001, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0001, 3'b000, 0, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0001, 3'b000, 0, 0, 4'b0001, F_NONE));
        st.push_back(mk(0, 4'b0001, 3'b000, 0, 0, 4'b0001, F_RW));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL ready_at_limit cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_illegal_halt();
        step_t st[$];
        st.push_back(mk(1, 4'b0101, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0101, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0101, 3'b000, 1, 0, 4'b0000, F_IL));
        st.push_back(mk(0, 4'b1111, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b1111, 3'b000, 1, 0, 4'b0000, F_NONE));
        for (int k = 0; k < 6; k++)
            st.push_back(mk(0, 4'b0011, 3'(k), k[0], 1, 4'b0000, F_HT));
        st.push_back(mk(1, 4'b0000, 3'b000, 0, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0000, 3'b000, 0, 0, 4'b0000, F_RD));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL illegal_halt cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        step_t st[$];
        st.push_back(mk(1, 4'b0011, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0011, 3'b000, 1, 0, 4'b0000, F_FETCH));
        st.push_back(mk(0, 4'b0011, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0011, F_NONE));
        st.push_back(mk(0, 4'b0011, 3'b000, 0, 0, 4'b0011, F_RD));
        st.push_back(mk(1, 4'b0011, 3'b000, 1, 0, 4'b0000, F_NONE));
        st.push_back(mk(0, 4'b0100, 3'b000, 0, 0, 4'b0000, F_RD));
        st.push_back(mk(0, 4'b0100, 3'b000, 1, 0, 4'b0000, F_FETCH));
        foreach (st[i]) begin
            applyStimulus(st[i]);
            @(negedge clk);
            expv = sb.pop_front();
            total++;
            if (obs !== expv) begin
                bad++;
                $display("[TB] FAIL reset_mid_mem cycle %0d: got %b want %b", i, obs, expv);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_rtype_back_to_back();
        test_lw_delayed();
        test_sw();
        test_beq();
        test_fetch_timeout();
        test_mem_timeout();
        test_ready_at_limit();
        test_illegal_halt();
        test_reset_mid_mem();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL provide parameter MEM_TIMEOUT, default 15: maximum wait cycles for mem_ready in IF/MEM before abort.
REQ-002 SHALL provide ports:
  clk  input  1  single system clock, rising edge.
  reset  input  1  asynchronous, active-high reset.
  opcode  input  4  instruction opcode field, valid while ir_write is high.
  funct  input  3  R-type function field, valid with opcode.
  mem_ready  input  1  memory handshake; access completes in the cycle it is high.
  zero  input  1  ALU zero flag, sampled in EX.
  op_fun  output  4  operation code to ALU control: 1fff R-type; 0001 addi; 0010 subi; 0011 lw; 0100 sw; 0110 beq; 0000 idle.
  mem_read  output  1  memory read request.
  mem_write  output  1  memory write request.
  ir_write  output  1  load instruction register.
  pc_write  output  1  PC <= PC+1.
  branch_taken  output  1  PC <= branch target.
  reg_write  output  1  register file write enable.
  illegal  output  1  one-cycle pulse on undefined opcode.
  mem_err  output  1  one-cycle pulse on handshake timeout.
  halted  output  1  high while in HALT.

Function
REQ-003 SHALL implement a Moore FSM with states IF, ID, EX, MEM, WB, HALT, encoded as 3-bit values.
REQ-004 IF: mem_read=1; on mem_ready=1, pulse ir_write=1 and pc_write=1 in that cycle and go to ID; otherwise stay in IF.
REQ-005 ID: register opcode/funct into internal decode registers; go to EX for 0000/0001/0010/0011/0100/0110; go to HALT for 1111; otherwise pulse illegal and go to IF.
REQ-006 EX: op_fun = {1,funct} for opcode 0000, else the opcode value; R/addi/subi go to WB; lw/sw go to MEM; beq asserts branch_taken=zero for this one cycle and goes to IF.
REQ-007 MEM: op_fun held; mem_read=1 for lw or mem_write=1 for sw; on mem_ready lw goes to WB, sw goes to IF; otherwise stay.
REQ-008 WB: op_fun held; reg_write=1 for exactly one cycle; go to IF.
REQ-009 HALT: all strobes 0, halted=1, op_fun=0000; exit only by reset.
REQ-010 op_fun SHALL be 0000 in IF, ID and HALT.
REQ-011 A wait counter SHALL clear on entry to IF or MEM, increment each cycle mem_ready is low there, and saturate at MEM_TIMEOUT.
REQ-012 When the counter equals MEM_TIMEOUT and mem_ready is low: pulse mem_err, drop the request, and go to IF without ir_write/pc_write/reg_write.
REQ-013 mem_ready in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally; no mem_err.
REQ-014 mem_ready SHALL be ignored outside IF and MEM.
REQ-015 mem_read and mem_write SHALL never be high together; at most one of ir_write/reg_write/branch_taken is high per cycle.
REQ-016 Throughput: R-type 4 cycles, lw 5, sw 4, beq 3, assuming mem_ready is high on the first request cycle.

Reset
REQ-017 reset high SHALL asynchronously force state IF, clear the counter and decode registers, and drive all outputs 0 (op_fun=0000); this SHALL also abort any in-flight access.
REQ-018 The first request SHALL be mem_read in the first clk edge-cycle after reset deasserts.

Structure
REQ-019 The shared package SHALL hold the state enum and op_fun/opcode localparams (OP_R, OP_ADDI, OP_SUBI, OP_LW, OP_SW, OP_BEQ, OP_HALT, OP_IDLE).
REQ-020 The wait counter SHALL be a sub-module mem_wait_timer (clear, enable, MEM_TIMEOUT parameter, expired output).

Verification
REQ-021 R-type: opcode 0000, funct 010, mem_ready tied 1 -> op_fun=1010 in EX and WB, reg_write on the 4th cycle.
REQ-022 lw with mem_ready delayed 3 cycles in MEM -> mem_read held 4 cycles, op_fun=0011, then WB reg_write; no mem_err.
REQ-023 beq with zero=1, then zero=0 -> branch_taken 1, then 0, in EX; op_fun=0110; return to IF.
REQ-024 mem_ready never asserted in IF, MEM_TIMEOUT=15 -> mem_err pulses on the 16th IF cycle with no ir_write; FSM restarts IF.
REQ-025 opcode 0101 -> illegal pulse in ID; opcode 1111 -> halted=1 indefinitely; reset asserted mid-MEM -> immediate IF, all outputs 0.
